// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory with variable latency, and latches illegal-instruction and timeout faults.
module riscv_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_Instr,
  input  logic        i_Zero,
  input  logic        i_MemReady,
  output logic [4:0]  o_AluOp,
  output logic [1:0]  o_AluSrcA,
  output logic        o_AluSrcB,
  output logic [2:0]  o_ImmSel,
  output logic        o_AdrSrc,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_IRWrite,
  output logic        o_PCWrite,
  output logic        o_RegWrite,
  output logic        o_ResultSrc,
  output logic [4:0]  o_State,
  output logic [1:0]  o_Fault
);

  typedef enum logic [4:0] {
    IDLE     = 5'd0,
    FETCH    = 5'd1,
    DECODE   = 5'd2,
    EXEC_R   = 5'd3,
    EXEC_I   = 5'd4,
    EXEC_U   = 5'd5,
    MEM_ADDR = 5'd6,
    MEM_RD   = 5'd7,
    MEM_WB   = 5'd8,
    MEM_WR   = 5'd9,
    ALU_WB   = 5'd10,
    BR_CMP   = 5'd11,
    BR_TGT   = 5'd12,
    BR_UPD   = 5'd13,
    J_TGT    = 5'd14,
    J_LINK   = 5'd15,
    HALT     = 5'd16
  } state_t;

  localparam logic [4:0] ALU_ADD   = 5'h01;
  localparam logic [4:0] ALU_SUB   = 5'h02;
  localparam logic [4:0] ALU_AND   = 5'h03;
  localparam logic [4:0] ALU_OR    = 5'h04;
  localparam logic [4:0] ALU_XOR   = 5'h05;
  localparam logic [4:0] ALU_SLL   = 5'h06;
  localparam logic [4:0] ALU_SRL   = 5'h07;
  localparam logic [4:0] ALU_SRA   = 5'h08;
  localparam logic [4:0] ALU_SLT   = 5'h09;
  localparam logic [4:0] ALU_LUI   = 5'h0A;
  localparam logic [4:0] ALU_SLTU  = 5'h0B;
  localparam logic [4:0] ALU_BGE   = 5'h0C;
  localparam logic [4:0] ALU_BGEU  = 5'h0D;
  localparam logic [4:0] ALU_ADDPC = 5'h0E;
  localparam logic [4:0] ALU_JBADR = 5'h0F;
  localparam logic [4:0] ALU_BNE   = 5'h10;
  localparam logic [4:0] ALU_BLT   = 5'h11;
  localparam logic [4:0] ALU_BLTU  = 5'h12;

  localparam logic [1:0] FAULT_ILL = 2'b01;
  localparam logic [1:0] FAULT_TMO = 2'b10;

  localparam int unsigned CW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

  state_t        state, state_next;
  logic [1:0]    fault, fault_next;
  logic [CW-1:0] wait_cnt;
  logic          taken;
  logic          mem_state, limit_hit;
  logic [4:0]    arith_op, br_op;
  logic          br_legal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       unused_instr_bits;

  assign opcode = i_Instr[6:0];
  assign funct3 = i_Instr[14:12];
  assign alt    = i_Instr[30];
  assign unused_instr_bits = ^{i_Instr[31], i_Instr[29:15], i_Instr[11:7]};

  assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // wait_cnt holds the number of non-ready cycles already spent, so this cycle is the limit-th
  assign limit_hit = (MEM_TIMEOUT != 0) && (wait_cnt == LIMIT_V);

  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = (state == EXEC_R && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    br_op    = '0;
    br_legal = 1'b1;
    case (funct3)
      3'b000:  br_op = ALU_SUB;
      3'b001:  br_op = ALU_BNE;
      3'b100:  br_op = ALU_BLT;
      3'b101:  br_op = ALU_BGE;
      3'b110:  br_op = ALU_BLTU;
      3'b111:  br_op = ALU_BGEU;
      default: br_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state;
    fault_next  = fault;
    o_AluOp     = '0;
    o_AluSrcA   = '0;
    o_AluSrcB   = 1'b0;
    o_ImmSel    = '0;
    o_AdrSrc    = 1'b0;
    o_MemRead   = 1'b0;
    o_MemWrite  = 1'b0;
    o_IRWrite   = 1'b0;
    o_PCWrite   = 1'b0;
    o_RegWrite  = 1'b0;
    o_ResultSrc = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        o_MemRead = 1'b1;
        o_AluOp   = ALU_ADDPC;
        o_IRWrite = i_MemReady;
        if (i_MemReady) state_next = DECODE;
      end
      DECODE: begin
        o_PCWrite = 1'b1;
        case (opcode)
          7'h33:          state_next = EXEC_R;
          7'h13:          state_next = EXEC_I;
          7'h37, 7'h17:   state_next = EXEC_U;
          7'h03, 7'h23:   state_next = MEM_ADDR;
          7'h63:          state_next = BR_CMP;
          7'h6F, 7'h67:   state_next = J_TGT;
          default: begin
            state_next = HALT;
            fault_next = FAULT_ILL;
          end
        endcase
      end
      EXEC_R, EXEC_I: begin
        o_AluOp    = arith_op;
        o_AluSrcA  = 2'd2;
        o_AluSrcB  = (state == EXEC_I);
        state_next = ALU_WB;
      end
      EXEC_U: begin
        o_ImmSel   = 3'd3;
        o_AluSrcB  = 1'b1;
        o_AluOp    = (opcode == 7'h37) ? ALU_LUI : ALU_JBADR;
        state_next = ALU_WB;
      end
      ALU_WB: begin
        o_RegWrite = 1'b1;
        state_next = FETCH;
      end
      MEM_ADDR: begin
        o_AluOp    = ALU_ADD;
        o_AluSrcA  = 2'd2;
        o_AluSrcB  = 1'b1;
        o_ImmSel   = (opcode == 7'h23) ? 3'd1 : 3'd0;
        state_next = (opcode == 7'h23) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        o_MemRead = 1'b1;
        o_AdrSrc  = 1'b1;
        if (i_MemReady) state_next = MEM_WB;
      end
      MEM_WB: begin
        o_RegWrite  = 1'b1;
        o_ResultSrc = 1'b1;
        state_next  = FETCH;
      end
      MEM_WR: begin
        o_MemWrite = 1'b1;
        o_AdrSrc   = 1'b1;
        if (i_MemReady) state_next = FETCH;
      end
      BR_CMP: begin
        o_AluOp   = br_op;
        o_AluSrcA = 2'd2;
        if (br_legal) state_next = BR_TGT;
        else begin
          state_next = HALT;
          fault_next = FAULT_ILL;
        end
      end
      BR_TGT: begin
        o_AluOp    = ALU_JBADR;
        o_AluSrcB  = 1'b1;
        o_ImmSel   = 3'd2;
        state_next = BR_UPD;
      end
      BR_UPD: begin
        o_PCWrite  = taken;
        state_next = FETCH;
      end
      J_TGT: begin
        o_AluSrcB = 1'b1;
        if (opcode == 7'h6F) begin
          o_AluOp  = ALU_JBADR;
          o_ImmSel = 3'd4;
        end else begin
          o_AluOp   = ALU_ADD;
          o_AluSrcA = 2'd2;
        end
        state_next = J_LINK;
      end
      J_LINK: begin
        o_PCWrite  = 1'b1;
        o_AluOp    = ALU_ADDPC;
        o_AluSrcA  = 2'd1;
        state_next = ALU_WB;
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
    // a ready in the limit cycle has already advanced the state above and is not overridden
    if (mem_state && !i_MemReady && limit_hit) begin
      state_next = HALT;
      fault_next = FAULT_TMO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fault    <= '0;
      wait_cnt <= '0;
      taken    <= 1'b0;
    end else begin
      state <= state_next;
      fault <= fault_next;
      if (state_next != state) wait_cnt <= '0;
      else if (mem_state && !i_MemReady) wait_cnt <= wait_cnt + CW'(1);
      if (state == BR_TGT) taken <= i_Zero;
    end
  end

  assign o_State = state;
  assign o_Fault = fault;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: directed vector table, hand sequences for reset/wait/timeout,
// and random instructions checked cycle by cycle against a per-instruction step-plan model.
module tb_riscv_multicycle_ctrl;
  localparam int unsigned TMO = 8;
  localparam logic [1:0] K_PLAIN = 2'd0, K_MEM = 2'd1, K_TGT = 2'd2, K_UPD = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] i_Instr = '0;
  logic        i_Zero = 1'b0;
  logic        i_MemReady = 1'b0;
  logic [4:0]  o_AluOp;
  logic [1:0]  o_AluSrcA;
  logic        o_AluSrcB;
  logic [2:0]  o_ImmSel;
  logic        o_AdrSrc, o_MemRead, o_MemWrite, o_IRWrite, o_PCWrite, o_RegWrite, o_ResultSrc;
  logic [4:0]  o_State;
  logic [1:0]  o_Fault;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .i_Instr(i_Instr), .i_Zero(i_Zero), .i_MemReady(i_MemReady),
    .o_AluOp(o_AluOp), .o_AluSrcA(o_AluSrcA), .o_AluSrcB(o_AluSrcB), .o_ImmSel(o_ImmSel),
    .o_AdrSrc(o_AdrSrc), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_IRWrite(o_IRWrite),
    .o_PCWrite(o_PCWrite), .o_RegWrite(o_RegWrite), .o_ResultSrc(o_ResultSrc),
    .o_State(o_State), .o_Fault(o_Fault)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] dut_vec();
    return {o_State, o_AluOp, o_AluSrcA, o_AluSrcB, o_ImmSel, o_AdrSrc, o_MemRead, o_MemWrite,
            o_IRWrite, o_PCWrite, o_RegWrite, o_ResultSrc, o_Fault};
  endfunction

  // ---------------- reference model: an instruction is a list of steps ----------------
  typedef struct packed {
    logic [4:0] st;
    logic [4:0] alu;
    logic [1:0] srca;
    logic       srcb;
    logic [2:0] imm;
    logic [6:0] strb;   // {adr, mrd, mwr, irw, pcw, rw, res}
    logic [1:0] kind;
  } step_t;

  step_t plan_q[$];
  logic [4:0] arith_tbl [8] = '{5'h01, 5'h06, 5'h09, 5'h0B, 5'h05, 5'h07, 5'h04, 5'h03};
  logic [4:0] br_tbl    [8] = '{5'h02, 5'h10, 5'h00, 5'h00, 5'h11, 5'h0C, 5'h12, 5'h0D};

  function automatic step_t mk(input logic [4:0] st, input logic [4:0] alu, input logic [1:0] srca,
                               input logic srcb, input logic [2:0] imm, input logic [6:0] strb,
                               input logic [1:0] kind);
    step_t s;
    s.st = st; s.alu = alu; s.srca = srca; s.srcb = srcb; s.imm = imm; s.strb = strb; s.kind = kind;
    return s;
  endfunction

  task automatic build_plan(input logic [31:0] ins, output logic [1:0] flt);
    logic [2:0] f3;
    logic [4:0] op;
    step_t wb;
    f3 = ins[14:12];
    wb = mk(5'd10, 5'h00, 2'd0, 1'b0, 3'd0, 7'b0000010, K_PLAIN);
    flt = 2'b00;
    plan_q.delete();
    plan_q.push_back(mk(5'd1, 5'h0E, 2'd0, 1'b0, 3'd0, 7'b0101000, K_MEM));
    plan_q.push_back(mk(5'd2, 5'h00, 2'd0, 1'b0, 3'd0, 7'b0000100, K_PLAIN));
    case (ins[6:0])
      7'h33, 7'h13: begin
        op = arith_tbl[f3];
        if (f3 == 3'd0 && ins[30] && ins[6:0] == 7'h33) op = 5'h02;
        if (f3 == 3'd5 && ins[30]) op = 5'h08;
        plan_q.push_back(mk((ins[6:0] == 7'h33) ? 5'd3 : 5'd4, op, 2'd2, ins[6:0] == 7'h13, 3'd0,
                            7'b0, K_PLAIN));
        plan_q.push_back(wb);
      end
      7'h37: begin
        plan_q.push_back(mk(5'd5, 5'h0A, 2'd0, 1'b1, 3'd3, 7'b0, K_PLAIN));
        plan_q.push_back(wb);
      end
      7'h17: begin
        plan_q.push_back(mk(5'd5, 5'h0F, 2'd0, 1'b1, 3'd3, 7'b0, K_PLAIN));
        plan_q.push_back(wb);
      end
      7'h03: begin
        plan_q.push_back(mk(5'd6, 5'h01, 2'd2, 1'b1, 3'd0, 7'b0, K_PLAIN));
        plan_q.push_back(mk(5'd7, 5'h00, 2'd0, 1'b0, 3'd0, 7'b1100000, K_MEM));
        plan_q.push_back(mk(5'd8, 5'h00, 2'd0, 1'b0, 3'd0, 7'b0000011, K_PLAIN));
      end
      7'h23: begin
        plan_q.push_back(mk(5'd6, 5'h01, 2'd2, 1'b1, 3'd1, 7'b0, K_PLAIN));
        plan_q.push_back(mk(5'd9, 5'h00, 2'd0, 1'b0, 3'd0, 7'b1010000, K_MEM));
      end
      7'h63: begin
        plan_q.push_back(mk(5'd11, br_tbl[f3], 2'd2, 1'b0, 3'd0, 7'b0, K_PLAIN));
        if (f3[2:1] == 2'b01) flt = 2'b01;
        else begin
          plan_q.push_back(mk(5'd12, 5'h0F, 2'd0, 1'b1, 3'd2, 7'b0, K_TGT));
          plan_q.push_back(mk(5'd13, 5'h00, 2'd0, 1'b0, 3'd0, 7'b0, K_UPD));
        end
      end
      7'h6F, 7'h67: begin
        if (ins[6:0] == 7'h6F) plan_q.push_back(mk(5'd14, 5'h0F, 2'd0, 1'b1, 3'd4, 7'b0, K_PLAIN));
        else                   plan_q.push_back(mk(5'd14, 5'h01, 2'd2, 1'b1, 3'd0, 7'b0, K_PLAIN));
        plan_q.push_back(mk(5'd15, 5'h0E, 2'd1, 1'b0, 3'd0, 7'b0000100, K_PLAIN));
        plan_q.push_back(wb);
      end
      default: flt = 2'b01;
    endcase
  endtask

  task automatic check_step(input step_t s, input logic irw, input logic pcw);
    logic [24:0] e;
    e = {s.st, s.alu, s.srca, s.srcb, s.imm, s.strb[6:4], irw, pcw, s.strb[1:0], 2'b00};
    check($sformatf("step st=%0d", s.st), dut_vec(), e);
  endtask

  task automatic rst_pulse();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic halt_and_reset(input logic [1:0] flt);
    repeat (2) begin
      i_MemReady = 1'($urandom); i_Zero = 1'($urandom);
      @(negedge clk);
      check("halt_hold", dut_vec(), {5'd16, 18'b0, flt});
      @(posedge clk); #1;
    end
    rst_n = 1'b0; #1;
    check("halt_reset_vec", dut_vec(), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // DUT is expected to be in its first fetch cycle, sampled just after a rising edge
  task automatic run_model(input logic [31:0] ins, input int unsigned maxw);
    logic [1:0] flt;
    logic taken, halted;
    int unsigned w, dly;
    step_t s;
    build_plan(ins, flt);
    taken = 1'b0; halted = 1'b0;
    i_Instr = ins;
    foreach (plan_q[i]) begin
      if (halted) break;
      s = plan_q[i];
      if (s.kind == K_MEM) begin
        dly = $urandom_range(maxw, 0); w = 0;
        for (int c = 0; c < int'(TMO); c++) begin
          i_MemReady = (w >= dly); i_Zero = 1'($urandom);
          @(negedge clk);
          check_step(s, s.strb[3] & i_MemReady, s.strb[2]);
          @(posedge clk); #1;
          if (i_MemReady) break;
          w++;
          if (w == TMO) begin flt = 2'b10; halted = 1'b1; break; end
        end
      end else begin
        i_MemReady = 1'($urandom); i_Zero = 1'($urandom);
        @(negedge clk);
        check_step(s, s.strb[3], (s.kind == K_UPD) ? taken : s.strb[2]);
        if (s.kind == K_TGT) taken = i_Zero;
        @(posedge clk); #1;
      end
    end
    if (flt != 2'b00) halt_and_reset(flt);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] ins;
    logic        zero;
    logic [4:0]  alu;    // AluOp in third cycle; 5'h1F = not compared
    logic        srcb;
    int unsigned cyc;
    int unsigned pcw;
    int unsigned rw;
    logic [1:0]  flt;
  } vec_t;

  vec_t tbl [17];
  logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                           7'h7F, 7'h0F, 7'h73};

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned cyc, npc, nrw, nf, ni, nr, idx, maxw;
    logic [4:0] alu_seen;
    logic srcb_seen, left;
    logic [31:0] ins;

    tbl[0]  = '{32'h002081B3, 1'b0, 5'h01, 1'b0, 4, 1, 1, 2'd0}; // add
    tbl[1]  = '{32'h402081B3, 1'b0, 5'h02, 1'b0, 4, 1, 1, 2'd0}; // sub
    tbl[2]  = '{32'h4030D093, 1'b0, 5'h08, 1'b1, 4, 1, 1, 2'd0}; // srai
    tbl[3]  = '{32'h00500093, 1'b0, 5'h01, 1'b1, 4, 1, 1, 2'd0}; // addi
    tbl[4]  = '{32'h0020B1B3, 1'b0, 5'h0B, 1'b0, 4, 1, 1, 2'd0}; // sltu
    tbl[5]  = '{32'h0040C093, 1'b0, 5'h05, 1'b1, 4, 1, 1, 2'd0}; // xori
    tbl[6]  = '{32'h123450B7, 1'b0, 5'h0A, 1'b1, 4, 1, 1, 2'd0}; // lui
    tbl[7]  = '{32'h00001097, 1'b0, 5'h0F, 1'b1, 4, 1, 1, 2'd0}; // auipc
    tbl[8]  = '{32'h0000A283, 1'b0, 5'h01, 1'b1, 5, 1, 1, 2'd0}; // lw
    tbl[9]  = '{32'h0050A223, 1'b0, 5'h01, 1'b1, 4, 1, 0, 2'd0}; // sw
    tbl[10] = '{32'h00208463, 1'b1, 5'h02, 1'b0, 5, 2, 0, 2'd0}; // beq taken
    tbl[11] = '{32'h00208463, 1'b0, 5'h02, 1'b0, 5, 1, 0, 2'd0}; // beq not taken
    tbl[12] = '{32'h0020E463, 1'b1, 5'h12, 1'b0, 5, 2, 0, 2'd0}; // bltu taken
    tbl[13] = '{32'h0020D463, 1'b0, 5'h0C, 1'b0, 5, 1, 0, 2'd0}; // bge not taken
    tbl[14] = '{32'h008000EF, 1'b0, 5'h0F, 1'b1, 5, 2, 1, 2'd0}; // jal
    tbl[15] = '{32'h000080E7, 1'b0, 5'h01, 1'b1, 5, 2, 1, 2'd0}; // jalr
    tbl[16] = '{32'h0020A463, 1'b0, 5'h1F, 1'b0, 3, 1, 0, 2'd1}; // branch funct3 010

    #2 rst_n = 1'b0;
    #1 check("reset_outputs_zero", dut_vec(), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_to_fetch", o_State, 32'd1);

    foreach (tbl[t]) begin
      rst_pulse();
      i_Instr = tbl[t].ins; i_MemReady = 1'b1; i_Zero = tbl[t].zero;
      cyc = 0; npc = 0; nrw = 0; alu_seen = '0; srcb_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (k == 2) begin alu_seen = o_AluOp; srcb_seen = o_AluSrcB; end
        if (o_State == 5'd16) break;
        cyc++; npc += o_PCWrite; nrw += o_RegWrite;
        @(posedge clk); #1;
        if (o_State == 5'd1) break;
      end
      if (tbl[t].alu != 5'h1F) check($sformatf("tbl%0d_aluop", t), alu_seen, tbl[t].alu);
      check($sformatf("tbl%0d_srcb", t), srcb_seen, tbl[t].srcb);
      check($sformatf("tbl%0d_cycles", t), cyc, tbl[t].cyc);
      check($sformatf("tbl%0d_pcwrite_cycles", t), npc, tbl[t].pcw);
      check($sformatf("tbl%0d_regwrite_cycles", t), nrw, tbl[t].rw);
      check($sformatf("tbl%0d_fault", t), o_Fault, tbl[t].flt);
    end

    // ADD with two wait cycles in fetch
    rst_pulse();
    i_Instr = 32'h002081B3;
    nf = 0; ni = 0; nr = 0; left = 1'b0;
    for (int k = 0; k < 12; k++) begin
      i_MemReady = (k >= 2);
      @(negedge clk);
      if (o_State == 5'd1) nf++;
      ni += o_IRWrite; nr += o_RegWrite;
      @(posedge clk); #1;
      if (o_State != 5'd1) left = 1'b1;
      else if (left) break;
    end
    check("wait2_fetch_cycles", nf, 32'd3);
    check("wait2_irwrite_cycles", ni, 32'd1);
    check("wait2_regwrite_cycles", nr, 32'd1);

    // reset in the middle of a store
    rst_pulse();
    i_Instr = 32'h0050A223; i_MemReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_MemReady = 1'b0;
    @(posedge clk); #1;
    check("store_in_mem_wr", {o_State, o_MemWrite, o_AdrSrc}, {5'd9, 1'b1, 1'b1});
    rst_n = 1'b0; #1;
    check("reset_mid_store_memwrite", o_MemWrite, 32'd0);
    check("reset_mid_store_state", o_State, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_store_refetch", {o_State, o_MemWrite, o_MemRead}, {5'd1, 1'b0, 1'b1});

    // fetch timeout
    rst_pulse();
    i_MemReady = 1'b0; nf = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_State != 5'd1) break;
      nf++;
      @(posedge clk); #1;
    end
    check("timeout_fetch_cycles", nf, TMO);
    check("timeout_state", o_State, 32'd16);
    check("timeout_fault", o_Fault, 32'd2);
    i_MemReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("timeout_sticky", dut_vec(), {5'd16, 18'b0, 2'b10});

    // ready arriving in the limit cycle is accepted
    rst_pulse();
    for (int k = 0; k < int'(TMO); k++) begin
      i_MemReady = (k == int'(TMO) - 1);
      @(posedge clk); #1;
    end
    check("ready_at_limit", {o_State, o_Fault}, {5'd2, 2'b00});

    // illegal opcode fault is sticky
    rst_pulse();
    i_Instr = 32'h0000007F; i_MemReady = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("illegal_sticky", dut_vec(), {5'd16, 18'b0, 2'b01});

    // random instructions against the step-plan model
    rst_pulse();
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      idx = $urandom_range(11, 0);
      if (idx >= 9 && $urandom_range(3, 0) != 0) idx = $urandom_range(8, 0);
      ins[6:0] = ops[idx];
      maxw = ($urandom_range(15, 0) == 0) ? 10 : $urandom_range(3, 0);
      run_model(ins, maxw);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
